// File: rtl/car_frame_parser_pkg.sv
// Shared constants and types for the car-park sensor frame parser.
// Frame on the wire: SOF, SENSOR, CAR, CHK with CHK = SOF ^ SENSOR ^ CAR.
package car_frame_pkg;

  localparam int         DEF_WIDTH          = 8;
  localparam int         DEF_TIMEOUT_CYCLES = 104160;
  localparam logic [7:0] DEF_SOF            = 8'hA5;

  localparam logic [7:0] SENSOR_ENTRY = 8'h00;
  localparam logic [7:0] SENSOR_EXIT  = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    GET_SENSOR,
    GET_CAR,
    GET_CHK
  } state_t;

endpackage

// File: rtl/car_frame_parser_if.sv
// Byte-in / event-out bundle between uart_rx, the frame parser and its consumer.
interface car_frame_parser_if #(
  parameter int width = 8
);

  logic [width-1:0] i_rx_data;
  logic             i_rx_done;
  logic             o_valid;
  logic             i_ready;
  logic             o_sensor;
  logic [width-1:0] o_car;
  logic             o_err;
  logic [7:0]       o_err_cnt;

  modport master (
    output i_rx_data, i_rx_done, i_ready,
    input  o_valid, o_sensor, o_car, o_err, o_err_cnt
  );

  modport slave (
    input  i_rx_data, i_rx_done, i_ready,
    output o_valid, o_sensor, o_car, o_err, o_err_cnt
  );

endinterface

// File: rtl/car_frame_parser_frame_timeout.sv
// Inter-byte gap counter: restarts on every byte, runs while a frame is open,
// and flags expire on the cycle the count sits at TIMEOUT_CYCLES-1.
module frame_timeout
  import car_frame_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear || !enable)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  // Not gated by clear: the parser gives a coinciding byte priority itself.
  assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/car_frame_parser.sv
// Parses SOF/SENSOR/CAR/CHK frames from uart_rx into a held car event with a
// valid/ready handshake, plus an error pulse and a saturating error counter.
module car_frame_parser
  import car_frame_pkg::*;
#(
  parameter int               width          = DEF_WIDTH,
  parameter int               TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [width-1:0] SOF            = width'(DEF_SOF)
) (
  input  logic               clk,
  input  logic               rst,
  car_frame_parser_if.slave  bus
);

  state_t           state, state_nxt;
  logic             sensor_q, sensor_nxt;
  logic [width-1:0] car_q, car_nxt;
  logic [width-1:0] chk_exp;
  logic             frame_ok, load, err, expire;

  logic             valid_q, out_sensor_q, err_q;
  logic [width-1:0] out_car_q;
  logic [7:0]       err_cnt_q;

  frame_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (bus.i_rx_done),
    .enable (state != IDLE),
    .expire (expire)
  );

  assign chk_exp = SOF ^ {{(width-1){1'b0}}, sensor_q} ^ car_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sensor_nxt = sensor_q;
    car_nxt    = car_q;
    frame_ok   = 1'b0;
    load       = 1'b0;
    err        = 1'b0;
    if (bus.i_rx_done) begin
      case (state)
        IDLE:
          if (bus.i_rx_data == SOF) state_nxt = GET_SENSOR;
        GET_SENSOR:
          if (bus.i_rx_data == width'(SENSOR_ENTRY) ||
              bus.i_rx_data == width'(SENSOR_EXIT)) begin
            sensor_nxt = bus.i_rx_data[0];
            state_nxt  = GET_CAR;
          end else begin
            err       = 1'b1;
            state_nxt = IDLE;
          end
        GET_CAR: begin
          car_nxt   = bus.i_rx_data;
          state_nxt = GET_CHK;
        end
        GET_CHK: begin
          state_nxt = IDLE;
          if (bus.i_rx_data == chk_exp) frame_ok = 1'b1;
          else                          err      = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (expire) begin
      state_nxt = IDLE;
      err       = 1'b1;
    end
    // A slot frees up when the held event is being accepted this very cycle.
    if (frame_ok) begin
      if (!valid_q || bus.i_ready) load = 1'b1;
      else                         err  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sensor_q     <= 1'b0;
      car_q        <= '0;
      valid_q      <= 1'b0;
      out_sensor_q <= 1'b0;
      out_car_q    <= '0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      sensor_q <= sensor_nxt;
      car_q    <= car_nxt;
      err_q    <= err;
      if (err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      if (load) begin
        valid_q      <= 1'b1;
        out_sensor_q <= sensor_q;
        out_car_q    <= car_q;
      end else if (valid_q && bus.i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_valid   = valid_q;
  assign bus.o_sensor  = out_sensor_q;
  assign bus.o_car     = out_car_q;
  assign bus.o_err     = err_q;
  assign bus.o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_car_frame_parser.sv
// Directed bench for car_frame_parser with a short gap timeout (20 cycles).
module tb_car_frame_parser;
  import car_frame_pkg::*;

  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  car_frame_parser_if #(.width(8)) bus ();

  car_frame_parser #(
    .width          (8),
    .TIMEOUT_CYCLES (TO),
    .SOF            (8'hA5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // One-cycle strobe; returns at the negedge after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_rx_data = 8'hA5;
    bus.i_rx_done = 1'b1;
    repeat (3) @(negedge clk);
    bus.i_rx_done = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_sensor !== 1'b0) begin failures++; $display("FAIL rst_sensor got=%b exp=0", bus.o_sensor); end
    checks++; if (bus.o_car !== 8'h00) begin failures++; $display("FAIL rst_car got=%h exp=00", bus.o_car); end
    checks++; if (bus.o_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus.o_err); end
    checks++; if (bus.o_err_cnt !== 8'd0) begin failures++; $display("FAIL rst_errcnt got=%0d exp=0", bus.o_err_cnt); end
    rst = 1'b0;
    // SOF strobed during reset must not open a frame
    send_byte(8'h00); send_byte(8'h07); send_byte(8'hA2);
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL rst_byte_ignored got=%b exp=0", bus.o_valid); end
  endtask

  task automatic test_good_frame();
    bus.i_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h07);
    @(negedge clk);
    bus.i_rx_data = 8'hA2;
    bus.i_rx_done = 1'b1;
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL good_early_valid got=%b exp=0", bus.o_valid); end
    @(negedge clk);
    bus.i_rx_done = 1'b0;
    checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL good_valid got=%b exp=1", bus.o_valid); end
    checks++; if (bus.o_sensor !== 1'b0) begin failures++; $display("FAIL good_sensor got=%b exp=0", bus.o_sensor); end
    checks++; if (bus.o_car !== 8'h07) begin failures++; $display("FAIL good_car got=%h exp=07", bus.o_car); end
    @(negedge clk);
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL good_valid_clear got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_err_cnt !== 8'd0) begin failures++; $display("FAIL good_errcnt got=%0d exp=0", bus.o_err_cnt); end
  endtask

  task automatic test_bad_chk();
    do_reset();
    bus.i_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h07); send_byte(8'h00);
    checks++; if (bus.o_err !== 1'b1) begin failures++; $display("FAIL chk_err got=%b exp=1", bus.o_err); end
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL chk_valid got=%b exp=0", bus.o_valid); end
    @(negedge clk);
    checks++; if (bus.o_err !== 1'b0) begin failures++; $display("FAIL chk_err_pulse got=%b exp=0", bus.o_err); end
    checks++; if (bus.o_err_cnt !== 8'd1) begin failures++; $display("FAIL chk_errcnt got=%0d exp=1", bus.o_err_cnt); end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12); send_byte(8'hB6);
    checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL chk_next_valid got=%b exp=1", bus.o_valid); end
    checks++; if (bus.o_sensor !== 1'b1) begin failures++; $display("FAIL chk_next_sensor got=%b exp=1", bus.o_sensor); end
    checks++; if (bus.o_car !== 8'h12) begin failures++; $display("FAIL chk_next_car got=%h exp=12", bus.o_car); end
    checks++; if (bus.o_err_cnt !== 8'd1) begin failures++; $display("FAIL chk_next_errcnt got=%0d exp=1", bus.o_err_cnt); end
  endtask

  task automatic test_bad_sensor();
    do_reset();
    send_byte(8'hA5); send_byte(8'h02);
    checks++; if (bus.o_err !== 1'b1) begin failures++; $display("FAIL sens_err got=%b exp=1", bus.o_err); end
    send_byte(8'h07); send_byte(8'hA2);
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL sens_valid got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_err_cnt !== 8'd1) begin failures++; $display("FAIL sens_errcnt got=%0d exp=1", bus.o_err_cnt); end
  endtask

  task automatic test_timeout();
    logic early;
    do_reset();
    send_byte(8'hA5); send_byte(8'h00);
    early = 1'b0;
    repeat (TO - 1) begin
      @(negedge clk);
      if (bus.o_err !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL to_early_err got=1 exp=0"); end
    @(negedge clk);
    checks++; if (bus.o_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", bus.o_err); end
    send_byte(8'h07); send_byte(8'hA2);
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL to_idle_valid got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_err_cnt !== 8'd1) begin failures++; $display("FAIL to_errcnt got=%0d exp=1", bus.o_err_cnt); end
    // byte strobed on the exact expire cycle wins
    do_reset();
    send_byte(8'hA5); send_byte(8'h00);
    repeat (TO - 2) @(negedge clk);
    send_byte(8'h07);
    checks++; if (bus.o_err !== 1'b0) begin failures++; $display("FAIL to_edge_err got=%b exp=0", bus.o_err); end
    send_byte(8'hA2);
    checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL to_edge_valid got=%b exp=1", bus.o_valid); end
    checks++; if (bus.o_err_cnt !== 8'd0) begin failures++; $display("FAIL to_edge_errcnt got=%0d exp=0", bus.o_err_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.i_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h07); send_byte(8'hA2);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12); send_byte(8'hB6);
    checks++; if (bus.o_err !== 1'b1) begin failures++; $display("FAIL bp_drop_err got=%b exp=1", bus.o_err); end
    checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", bus.o_valid); end
    checks++; if (bus.o_car !== 8'h07) begin failures++; $display("FAIL bp_car got=%h exp=07", bus.o_car); end
    checks++; if (bus.o_sensor !== 1'b0) begin failures++; $display("FAIL bp_sensor got=%b exp=0", bus.o_sensor); end
    checks++; if (bus.o_err_cnt !== 8'd1) begin failures++; $display("FAIL bp_errcnt got=%0d exp=1", bus.o_err_cnt); end
    bus.i_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL bp_consume got=%b exp=0", bus.o_valid); end
    @(negedge clk);
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL bp_consume_once got=%b exp=0", bus.o_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.i_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h07); send_byte(8'hA2);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12);
    @(negedge clk);
    bus.i_rx_data = 8'hB6;
    bus.i_rx_done = 1'b1;
    bus.i_ready   = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
    checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", bus.o_valid); end
    checks++; if (bus.o_car !== 8'h12) begin failures++; $display("FAIL b2b_car got=%h exp=12", bus.o_car); end
    checks++; if (bus.o_sensor !== 1'b1) begin failures++; $display("FAIL b2b_sensor got=%b exp=1", bus.o_sensor); end
    checks++; if (bus.o_err !== 1'b0) begin failures++; $display("FAIL b2b_err got=%b exp=0", bus.o_err); end
    @(negedge clk);
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL b2b_clear got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_err_cnt !== 8'd0) begin failures++; $display("FAIL b2b_errcnt got=%0d exp=0", bus.o_err_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.i_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h07); send_byte(8'h00);
    end
    checks++; if (bus.o_err_cnt !== 8'd255) begin failures++; $display("FAIL sat_errcnt got=%0d exp=255", bus.o_err_cnt); end
    bus.i_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h33); send_byte(8'h97);
    send_byte(8'hA5); send_byte(8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_sensor !== 1'b0) begin failures++; $display("FAIL mid_sensor got=%b exp=0", bus.o_sensor); end
    checks++; if (bus.o_car !== 8'h00) begin failures++; $display("FAIL mid_car got=%h exp=00", bus.o_car); end
    checks++; if (bus.o_err !== 1'b0) begin failures++; $display("FAIL mid_err got=%b exp=0", bus.o_err); end
    checks++; if (bus.o_err_cnt !== 8'd0) begin failures++; $display("FAIL mid_errcnt got=%0d exp=0", bus.o_err_cnt); end
    send_byte(8'h07); send_byte(8'hA2);
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL mid_partial got=%b exp=0", bus.o_valid); end
  endtask

  initial begin
    bus.i_rx_data = 8'h00;
    bus.i_rx_done = 1'b0;
    bus.i_ready   = 1'b1;
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_bad_sensor();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
